// File: rtl/load_store_queue_pkg.sv
// Shared LSQ types: CDB broadcast, head packet, slot state, transfer sizes.
package load_store_queue_pkg;

  localparam int LSQ_ROB_W = 4;

  localparam logic [1:0] XFER_WORD = 2'b00;
  localparam logic [1:0] XFER_BYTE = 2'b01;
  localparam logic [1:0] XFER_HALF = 2'b10;

  typedef struct packed {
    logic [LSQ_ROB_W-1:0] dest_ROB_entry;
    logic [31:0]          result;
  } CDB_packet_t;

  typedef struct packed {
    logic [31:0]          address;
    logic [31:0]          result;
    logic [1:0]           xfer_size;
    logic                 lsq_signed;
    logic [LSQ_ROB_W-1:0] ROB_entry;
  } lsq_packet_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_load;
    logic [LSQ_ROB_W-1:0] ROB_entry;
    logic [1:0]           xfer_size;
    logic                 lsq_signed;
    logic [31:0]          address;
    logic                 addr_valid;
    logic [31:0]          result;
    logic                 data_valid;
    logic [LSQ_ROB_W-1:0] data_tag;
  } lsq_entry_t;

endpackage

// File: rtl/load_store_queue_if.sv
// LSQ bus: dispatch alloc, AGU, CDB, memory-controller dequeue and head view.
// The flush signal exists only when LSQ_FLUSH_EN is defined.
interface load_store_queue_if
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROB_W = LSQ_ROB_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alloc_valid;
  logic              alloc_is_load;
  logic [ROB_W-1:0]  alloc_rob_entry;
  logic [1:0]        alloc_xfer_size;
  logic              alloc_signed;
  logic              alloc_data_ready;
  logic [31:0]       alloc_data;
  logic [ROB_W-1:0]  alloc_data_tag;
  logic              agu_valid;
  logic [ROB_W-1:0]  agu_rob_entry;
  logic [31:0]       agu_address;
  logic              cdb_valid;
  CDB_packet_t       cdb_in;
  logic              rd_en;
`ifdef LSQ_FLUSH_EN
  logic              flush;
`endif
  lsq_packet_t       mem_in;
  logic              head_load;
  logic              head_ready;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;

  modport master (
    output alloc_valid, alloc_is_load, alloc_rob_entry, alloc_xfer_size,
           alloc_signed, alloc_data_ready, alloc_data, alloc_data_tag,
           agu_valid, agu_rob_entry, agu_address, cdb_valid, cdb_in, rd_en,
`ifdef LSQ_FLUSH_EN
           flush,
`endif
    input  mem_in, head_load, head_ready, empty, full, count
  );

  modport slave (
    input  alloc_valid, alloc_is_load, alloc_rob_entry, alloc_xfer_size,
           alloc_signed, alloc_data_ready, alloc_data, alloc_data_tag,
           agu_valid, agu_rob_entry, agu_address, cdb_valid, cdb_in, rd_en,
`ifdef LSQ_FLUSH_EN
           flush,
`endif
    output mem_in, head_load, head_ready, empty, full, count
  );

endinterface

// File: rtl/load_store_queue_slot.sv
// One LSQ entry: storage plus AGU address and CDB store-data capture.
module lsq_slot
  import load_store_queue_pkg::*;
#(
  parameter int ROB_W = LSQ_ROB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,       // flush: drop entry
  input  logic             wr_en_i,     // allocation into this slot
  input  lsq_entry_t       wr_ent_i,
  input  logic             deq_i,       // head dequeue of this slot
  input  logic             agu_valid_i,
  input  logic [ROB_W-1:0] agu_rob_i,
  input  logic [31:0]      agu_addr_i,
  input  logic             cdb_valid_i,
  input  logic [ROB_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_result_i,
  output logic             valid_o,
  output logic             is_load_o,
  output logic             ready_o,
  output lsq_packet_t      pkt_o
);

  lsq_entry_t ent_q, ent_d;
  logic       agu_hit, cdb_hit;

  // Captures first, then allocation, then removal; removal always wins.
  always_comb begin
    ent_d   = ent_q;
    agu_hit = agu_valid_i & ent_q.valid & ~ent_q.addr_valid &
              (ent_q.ROB_entry == agu_rob_i);
    cdb_hit = cdb_valid_i & ent_q.valid & ~ent_q.is_load & ~ent_q.data_valid &
              (ent_q.data_tag == cdb_tag_i);
    if (agu_hit) begin
      ent_d.address    = agu_addr_i;
      ent_d.addr_valid = 1'b1;
    end
    if (cdb_hit) begin
      ent_d.result     = cdb_result_i;
      ent_d.data_valid = 1'b1;
    end
    if (wr_en_i) ent_d = wr_ent_i;
    if (deq_i | clr_i) ent_d.valid = 1'b0;
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (reset) ent_q <= '0;
    else       ent_q <= ent_d;
  end

  assign valid_o   = ent_q.valid;
  assign is_load_o = ent_q.is_load;
  assign ready_o   = ent_q.valid & ent_q.addr_valid &
                     (ent_q.is_load | ent_q.data_valid);
  assign pkt_o     = '{address:    ent_q.address,
                       result:     ent_q.result,
                       xfer_size:  ent_q.xfer_size,
                       lsq_signed: ent_q.lsq_signed,
                       ROB_entry:  ent_q.ROB_entry};

endmodule

// File: rtl/load_store_queue.sv
// In-order circular load/store queue. Pointers, count, CDB alloc bypass and
// head mux live here; per-entry capture lives in lsq_slot.
// Optional feature macro: LSQ_FLUSH_EN (adds the flush input).
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROB_W = LSQ_ROB_W
) (
  input  logic               clk,
  input  logic               reset,
  load_store_queue_if.slave  lsq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_w, full_w, do_alloc, do_deq, flush_w, bypass;
  lsq_entry_t       alloc_ent;

  logic [DEPTH-1:0] slot_vld, slot_load, slot_rdy;
  lsq_packet_t      slot_pkt [DEPTH];

`ifdef LSQ_FLUSH_EN
  assign flush_w = lsq.flush;
`else
  assign flush_w = 1'b0;
`endif

  // Full/empty come from the registered count, so a dequeue never frees
  // room for an allocation in the same cycle.
  assign empty_w  = (count_q == '0);
  assign full_w   = (count_q == CNT_W'(DEPTH));
  assign do_alloc = lsq.alloc_valid & ~full_w & ~flush_w;
  assign do_deq   = lsq.rd_en & ~empty_w & ~flush_w;

  // New entry image, with same-cycle CDB bypass for pending store data.
  always_comb begin
    bypass = ~lsq.alloc_is_load & ~lsq.alloc_data_ready & lsq.cdb_valid &
             (lsq.cdb_in.dest_ROB_entry == lsq.alloc_data_tag);
    alloc_ent            = '0;
    alloc_ent.valid      = 1'b1;
    alloc_ent.is_load    = lsq.alloc_is_load;
    alloc_ent.ROB_entry  = lsq.alloc_rob_entry;
    alloc_ent.xfer_size  = lsq.alloc_xfer_size;
    alloc_ent.lsq_signed = lsq.alloc_signed;
    alloc_ent.data_tag   = lsq.alloc_data_tag;
    alloc_ent.result     = bypass ? lsq.cdb_in.result : lsq.alloc_data;
    alloc_ent.data_valid = lsq.alloc_is_load | lsq.alloc_data_ready | bypass;
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      lsq_slot #(.ROB_W(ROB_W)) u_slot (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (flush_w),
        .wr_en_i      (do_alloc & (tail_q == PTR_W'(i))),
        .wr_ent_i     (alloc_ent),
        .deq_i        (do_deq & (head_q == PTR_W'(i))),
        .agu_valid_i  (lsq.agu_valid),
        .agu_rob_i    (lsq.agu_rob_entry),
        .agu_addr_i   (lsq.agu_address),
        .cdb_valid_i  (lsq.cdb_valid),
        .cdb_tag_i    (lsq.cdb_in.dest_ROB_entry),
        .cdb_result_i (lsq.cdb_in.result),
        .valid_o      (slot_vld[i]),
        .is_load_o    (slot_load[i]),
        .ready_o      (slot_rdy[i]),
        .pkt_o        (slot_pkt[i])
      );
    end
  endgenerate

  // Pointer and occupancy next state; flush empties the queue.
  always_comb begin
    head_d  = head_q + PTR_W'(do_deq);
    tail_d  = tail_q + PTR_W'(do_alloc);
    count_d = count_q;
    case ({do_alloc, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_w) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign lsq.mem_in     = slot_pkt[head_q];
  assign lsq.head_load  = ~empty_w & slot_vld[head_q] & slot_load[head_q];
  assign lsq.head_ready = ~empty_w & slot_rdy[head_q];
  assign lsq.empty      = empty_w;
  assign lsq.full       = full_w;
  assign lsq.count      = count_q;

endmodule

// File: doc/load_store_queue.md
# load_store_queue

In-order circular load/store queue between dispatch and the memory controller. Dispatch allocates one entry per memory instruction. Addresses come from the AGU and store data from CDB snooping. The head entry is presented as an `lsq_packet_t` together with `head_load`, `head_ready` and `empty`, and is removed when the memory controller pulses `rd_en`.

## Interface
- `DEPTH`, 8, number of entries (power of two, ≥2)
- `ROB_W`, 4, ROB tag width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- alloc_valid  in  1  dispatch requests an entry
- alloc_is_load  in  1  1 = load, 0 = store
- alloc_rob_entry  in  ROB_W  ROB tag of the instruction
- alloc_xfer_size  in  2  transfer size: 01 byte, 10 half, 00/11 word
- alloc_signed  in  1  sign-extend load result
- alloc_data_ready  in  1  store data already available
- alloc_data  in  32  store data (when ready)
- alloc_data_tag  in  ROB_W  ROB tag producing the store data (when not ready)
- agu_valid  in  1  address result valid
- agu_rob_entry  in  ROB_W  ROB tag the address belongs to
- agu_address  in  32  effective address
- cdb_valid  in  1  CDB broadcast valid
- cdb_in  in  CDB_packet_t  broadcast (uses dest_ROB_entry, result)
- rd_en  in  1  dequeue head
- flush  in  1  discard all entries (only with LSQ_FLUSH_EN)
- mem_in  out  lsq_packet_t  head entry contents
- head_load  out  1  head is a load
- head_ready  out  1  head address valid, and data valid if store
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Slot state per entry: valid, is_load, ROB_entry, xfer_size, lsq_signed, address, addr_valid, result (store data), data_valid, data_tag.
- Pointers: head and tail, each $clog2(DEPTH) bits, wrap modulo DEPTH. A separate count register.
- Allocate when `alloc_valid & ~full`:
  - The slot at tail is written: valid=1, addr_valid=0, data_valid = alloc_is_load | alloc_data_ready.
  - tail increments.
  - `alloc_valid` while full is ignored; dispatch must stall on `full`.
- Full and empty are computed from count before the cycle's dequeue. A dequeue does not make room for an alloc in the same cycle.
- Dequeue when `rd_en & ~empty`:
  - The head slot's valid bit is cleared and head increments.
  - `rd_en` while empty is ignored.
- count: +1 on alloc only, −1 on dequeue only, unchanged on both or neither.
- AGU capture: every valid slot with addr_valid=0 and ROB_entry == agu_rob_entry takes address = agu_address and sets addr_valid=1. Tags are unique, so at most one slot matches.
  - An AGU result for the entry being allocated in the same cycle is not captured. Upstream guarantees the AGU result arrives at least one cycle after allocation.
- CDB capture: every valid store slot with data_valid=0 and data_tag == cdb_in.dest_ROB_entry takes result = cdb_in.result and sets data_valid=1.
  - Alloc bypass: if a store allocates with alloc_data_ready=0 while cdb_valid carries its alloc_data_tag, the slot is written with the CDB result and data_valid=1.
- Head outputs are combinational from the head slot:
  - mem_in = {address, result, xfer_size, lsq_signed, ROB_entry}.
  - head_load = ~empty & is_load.
  - head_ready = ~empty & addr_valid & (is_load | data_valid).
  - When empty, mem_in fields are don't-care.
- Simultaneous AGU or CDB capture and dequeue on the head slot: the dequeue wins and the slot becomes invalid.

## Timing
- Reset values: head=0, tail=0, count=0, all valid=0, empty=1, full=0, head_load=0, head_ready=0.
- Reset overrides every other input in the same cycle.
- An alloc at edge N is visible at the head by cycle N+1 if the queue was empty.
- AGU/CDB capture at edge N is reflected in head_ready from cycle N+1. There is no combinational path from agu_* or cdb_* to any output.
- Dequeue at edge N makes the next entry the head in cycle N+1. Back-to-back `rd_en` can therefore drain one entry per cycle.
- Sustained throughput: one alloc and one dequeue per cycle.

## Configuration
- `LSQ_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush` at edge N clears all valid bits and sets head=tail=0, count=0, so empty=1 in cycle N+1.
  - flush overrides alloc, rd_en and captures in that cycle; reset still has priority over flush.
- `LSQ_FLUSH_EN` undefined: no `flush` port; entries leave only through dequeue or reset.

## Structure
- `lsq_packet_t`, `CDB_packet_t` and the xfer_size encodings live in the shared `structs.sv` package.
- Add `lsq_entry_t` (the slot state) to the same package.
- One sub-module, `lsq_slot`: single-entry storage with AGU/CDB tag compare and capture logic, instantiated DEPTH times.
- Pointers, count, alloc bypass and head mux stay in `load_store_queue`.

## Test plan
- Reset, then alloc a load (ROB 3, addr later) -> empty=0, count=1, head_load=1, head_ready=0; AGU tag 3 addr 0x40 -> next cycle head_ready=1, mem_in.address=0x40.
- Alloc a store (ROB 5, data_tag 2, not ready) with cdb_valid tag 2 result 0xDEADBEEF in the same cycle -> slot data_valid=1, result=0xDEADBEEF; after AGU, head_ready=1 and head_load=0.
- Fill 8 entries -> full=1, count=8; 9th alloc with rd_en in the same cycle -> alloc rejected, count=7, tail unchanged.
- Alloc and dequeue every cycle for 20 cycles across the pointer wrap -> count stays constant and dequeue order equals allocation order of ROB tags.
- rd_en while empty, and AGU with a non-matching tag -> no state change, count=0.
- With LSQ_FLUSH_EN: 5 entries plus flush asserted with alloc_valid -> next cycle empty=1, count=0, and the allocating entry is discarded.
